gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 5, giving the number of port pins (legal range 1..32).
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal range 2..4).
REQ-003 The block SHALL provide parameter TRIS_RST, default all-ones, giving the direction register reset value (1 = input).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, exposed as ports clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 pin_in  input  WIDTH  raw asynchronous pad levels.
REQ-008 pin_out  output  WIDTH  output data latch driven to the pads.
REQ-009 pin_oe  output  WIDTH  pad output enable, equal to the bitwise inverse of the TRIS register.
REQ-010 wr_port  input  1  strobe that writes wr_data into the output latch.
REQ-011 wr_tris  input  1  strobe that writes wr_data into the TRIS register.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 rd_port  input  1  port-read strobe, which refreshes the change snapshot.
REQ-014 port_rd_data  output  WIDTH  synchronised pin levels.
REQ-015 tris_rd_data  output  WIDTH  current TRIS register.
REQ-016 ioc_mask  input  WIDTH  per-bit interrupt-on-change enable.
REQ-017 ioc_clr  input  1  clear strobe for the change flag.
REQ-018 ioc_flag  output  1  sticky interrupt-on-change flag.

Function
REQ-019 pin_in SHALL pass through a SYNC_STAGES-deep flop chain, so a pin edge appears on port_rd_data exactly SYNC_STAGES rising edges later.
REQ-020 port_rd_data SHALL always show the synchronised pin levels, regardless of TRIS.
REQ-021 wr_port SHALL load wr_data into the latch on the next rising edge, and pin_out SHALL update in that same cycle.
REQ-022 wr_tris SHALL load wr_data into TRIS on the next rising edge, and pin_oe SHALL equal ~TRIS combinationally.
REQ-023 When wr_port and wr_tris are asserted in the same cycle, both registers SHALL load wr_data.
REQ-024 A rd_port strobe SHALL copy the synchronised levels into the snapshot register on the next rising edge.
REQ-025 The block SHALL form a mismatch vector as (sync ^ snapshot) & ioc_mask & TRIS; bits configured as outputs SHALL never raise the flag.
REQ-026 ioc_flag SHALL set on the rising edge after the mismatch vector becomes nonzero, and SHALL then hold until ioc_clr is asserted.
REQ-027 When ioc_clr and a nonzero mismatch vector occur in the same cycle, set SHALL win and ioc_flag SHALL remain 1.
REQ-028 When rd_port and a pin change occur in the same cycle, the snapshot SHALL take the post-change synchronised value, and the flag SHALL set only if the mismatch vector was nonzero in that cycle.
REQ-029 Changing ioc_mask or TRIS SHALL take effect on the mismatch vector in the same cycle; no history is retained.

Reset
REQ-030 Asserting rst SHALL immediately force the following, independent of clk: synchroniser flops 0, snapshot 0, latch 0 (pin_out = 0), TRIS = TRIS_RST, pin_oe = ~TRIS_RST, ioc_flag 0.
REQ-031 Reset asserted mid-operation SHALL discard pending writes, and the first write SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 With macro GPIO_PORT_IOC_EN defined, the snapshot, mismatch and flag logic SHALL be present as specified in REQ-024 to REQ-028.
REQ-033 Without GPIO_PORT_IOC_EN, ioc_flag SHALL be tied 0, the snapshot SHALL be removed, and rd_port, ioc_mask and ioc_clr SHALL be ignored; all other behaviour SHALL be unchanged.

Structure
REQ-034 Package gpio_pkg SHALL hold the WIDTH maximum constant (32), the SYNC_STAGES limits, and the default TRIS_RST constant.
REQ-035 Sub-module gpio_sync SHALL implement the parametrised WIDTH x SYNC_STAGES synchroniser; all other logic SHALL stay in gpio_port.

Verification
REQ-036 Reset check: WIDTH=5, pulse rst -> pin_out=5'h00, tris_rd_data=5'h1F, pin_oe=5'h00, ioc_flag=0, with no clock edge required.
REQ-037 Latch and TRIS write: wr_port with wr_data=5'h15, then wr_tris with 5'h0F -> pin_out=5'h15 and pin_oe=5'h10, each one edge after its strobe.
REQ-038 Synchroniser latency: SYNC_STAGES=3, drive pin_in from 5'h00 to 5'h04 -> port_rd_data=5'h04 exactly 3 edges later and not earlier.
REQ-039 Change detect (macro defined): TRIS=5'h1F, ioc_mask=5'h03, rd_port, then toggle pin 1 -> ioc_flag=1; a subsequent toggle of pin 3 alone after clear -> ioc_flag stays 0.
REQ-040 Clear/set collision: hold a mismatch and assert ioc_clr -> ioc_flag remains 1; rd_port then ioc_clr -> ioc_flag=0.
REQ-041 Macro absent: repeat the REQ-039 stimulus -> ioc_flag=0 throughout.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared limits and reset defaults for the gpio_port slice
package gpio_pkg;

    localparam int GPIO_WIDTH_MAX = 32;
    localparam int GPIO_SYNC_MIN  = 2;
    localparam int GPIO_SYNC_MAX  = 4;

    localparam logic [GPIO_WIDTH_MAX-1:0] GPIO_TRIS_RST_DEFAULT = '1;

    // Out-of-range depths collapse to the nearest legal depth rather than break elaboration.
    function automatic int gpio_sync_depth(input int stages);
        if (stages < GPIO_SYNC_MIN) begin
            return GPIO_SYNC_MIN;
        end
        if (stages > GPIO_SYNC_MAX) begin
            return GPIO_SYNC_MAX;
        end
        return stages;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - WIDTH x STAGES flop chain bringing raw pad levels into the clk domain
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int DEPTH = gpio_sync_depth(STAGES);

    logic [WIDTH-1:0] chain_q [DEPTH];
    logic [WIDTH-1:0] chain_d [DEPTH];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - GPIO port: output latch, TRIS, input sync, interrupt-on-change
// Interrupt-on-change logic is built only when GPIO_PORT_IOC_EN is defined.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TRIS_RST    = GPIO_TRIS_RST_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    input  logic             wr_port,
    input  logic             wr_tris,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_port,
    output logic [WIDTH-1:0] port_rd_data,
    output logic [WIDTH-1:0] tris_rd_data,
    input  logic [WIDTH-1:0] ioc_mask,
    input  logic             ioc_clr,
    output logic             ioc_flag
);

    logic [WIDTH-1:0] sync_pins;
    logic [WIDTH-1:0] port_q, port_d;
    logic [WIDTH-1:0] tris_q, tris_d;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (sync_pins)
    );

    // Simultaneous port and TRIS strobes both load the same write data.
    always_comb begin
        port_d = port_q;
        tris_d = tris_q;
        if (wr_port) begin
            port_d = wr_data;
        end
        if (wr_tris) begin
            tris_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q <= '0;
            tris_q <= TRIS_RST;
        end else begin
            port_q <= port_d;
            tris_q <= tris_d;
        end
    end

    assign pin_out      = port_q;
    assign pin_oe       = ~tris_q;
    assign tris_rd_data = tris_q;
    assign port_rd_data = sync_pins;

`ifdef GPIO_PORT_IOC_EN
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] mismatch;

    // Output-configured bits (TRIS=0) are masked out so driven pins never raise the flag.
    assign mismatch = (sync_pins ^ snap_q) & ioc_mask & tris_q;

    always_comb begin
        snap_d = snap_q;
        flag_d = flag_q;
        if (rd_port) begin
            snap_d = sync_pins;
        end
        if (|mismatch) begin
            flag_d = 1'b1;
        end else if (ioc_clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            flag_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            flag_q <= flag_d;
        end
    end

    assign ioc_flag = flag_q;
`else
    logic unused_ioc_inputs;

    assign unused_ioc_inputs = rd_port ^ ioc_clr ^ (^ioc_mask);
    assign ioc_flag          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - randomized and directed self-checking bench for gpio_port
module tb_gpio_port;

    localparam int W  = 5;
    localparam int SS = 3;
`ifdef GPIO_PORT_IOC_EN
    localparam bit IOC_EN = 1'b1;
`else
    localparam bit IOC_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] pin_in;
    logic [W-1:0] pin_out;
    logic [W-1:0] pin_oe;
    logic         wr_port;
    logic         wr_tris;
    logic [W-1:0] wr_data;
    logic         rd_port;
    logic [W-1:0] port_rd_data;
    logic [W-1:0] tris_rd_data;
    logic [W-1:0] ioc_mask;
    logic         ioc_clr;
    logic         ioc_flag;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pin history delay line plus architectural registers.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_port;
    logic [W-1:0] m_tris;
    logic [W-1:0] m_snap;
    logic         m_flag;

    gpio_port #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .TRIS_RST    (5'h1F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pin_in       (pin_in),
        .pin_out      (pin_out),
        .pin_oe       (pin_oe),
        .wr_port      (wr_port),
        .wr_tris      (wr_tris),
        .wr_data      (wr_data),
        .rd_port      (rd_port),
        .port_rd_data (port_rd_data),
        .tris_rd_data (tris_rd_data),
        .ioc_mask     (ioc_mask),
        .ioc_clr      (ioc_clr),
        .ioc_flag     (ioc_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < SS; i++) begin
            hist.push_back('0);
        end
        m_port = '0;
        m_tris = '1;
        m_snap = '0;
        m_flag = 1'b0;
    endtask

    task automatic check_all();
        logic [W-1:0] exp_oe;
        exp_oe = ~m_tris;
        check_eq("pin_out", pin_out, m_port);
        check_eq("pin_oe", pin_oe, exp_oe);
        check_eq("tris_rd_data", tris_rd_data, m_tris);
        check_eq("port_rd_data", port_rd_data, hist[0]);
        check_eq("ioc_flag", ioc_flag, m_flag);
    endtask

    task automatic tick();
        logic [W-1:0] sync_m;
        logic [W-1:0] mism;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            sync_m = hist[0];
            mism   = (sync_m ^ m_snap) & ioc_mask & m_tris;
            if (IOC_EN) begin
                if (mism != '0) m_flag = 1'b1;
                else if (ioc_clr) m_flag = 1'b0;
                if (rd_port) m_snap = sync_m;
            end
            if (wr_port) m_port = wr_data;
            if (wr_tris) m_tris = wr_data;
            hist.push_back(pin_in);
            void'(hist.pop_front());
        end
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        pin_in   = '0;
        wr_port  = 1'b0;
        wr_tris  = 1'b0;
        wr_data  = '0;
        rd_port  = 1'b0;
        ioc_mask = '0;
        ioc_clr  = 1'b0;
        #2;

        // Asynchronous reset, observed before any clock edge.
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_pin_out", pin_out, 32'h00);
        check_eq("rst_tris", tris_rd_data, 32'h1F);
        check_eq("rst_pin_oe", pin_oe, 32'h00);
        check_eq("rst_ioc_flag", ioc_flag, 32'h0);
        tick();
        rst = 1'b0;

        // Latch then TRIS write.
        wr_port = 1'b1; wr_data = 5'h15;
        tick();
        check_eq("wr_port_out", pin_out, 32'h15);
        wr_port = 1'b0; wr_tris = 1'b1; wr_data = 5'h0F;
        tick();
        check_eq("wr_tris_oe", pin_oe, 32'h10);
        wr_tris = 1'b0;

        // Synchroniser latency.
        pin_in = 5'h04;
        tick(); check_eq("sync_edge1", port_rd_data, 32'h00);
        tick(); check_eq("sync_edge2", port_rd_data, 32'h00);
        tick(); check_eq("sync_edge3", port_rd_data, 32'h04);

        // Change detect on masked input pin, then unmasked pin after clear.
        wr_tris = 1'b1; wr_data = 5'h1F; ioc_mask = 5'h03;
        tick();
        wr_tris = 1'b0; rd_port = 1'b1;
        tick();
        rd_port = 1'b0; pin_in = pin_in ^ 5'h02;
        tick(); tick(); tick();
        check_eq("ioc_not_yet", ioc_flag, 32'h0);
        tick();
        check_eq("ioc_set_pin1", ioc_flag, {31'b0, IOC_EN});
        rd_port = 1'b1;
        tick();
        rd_port = 1'b0; ioc_clr = 1'b1;
        tick();
        check_eq("ioc_cleared", ioc_flag, 32'h0);
        ioc_clr = 1'b0; pin_in = pin_in ^ 5'h08;
        repeat (5) tick();
        check_eq("ioc_pin3_masked", ioc_flag, 32'h0);

        // Clear loses against a held mismatch.
        pin_in = pin_in ^ 5'h01;
        repeat (4) tick();
        ioc_clr = 1'b1;
        tick(); tick();
        check_eq("ioc_clr_collision", ioc_flag, {31'b0, IOC_EN});
        ioc_clr = 1'b0; rd_port = 1'b1;
        tick();
        rd_port = 1'b0; ioc_clr = 1'b1;
        tick();
        check_eq("ioc_clr_after_read", ioc_flag, 32'h0);
        ioc_clr = 1'b0;

        // Output-configured bit never raises the flag.
        wr_tris = 1'b1; wr_data = 5'h1E;
        tick();
        wr_tris = 1'b0; pin_in = pin_in ^ 5'h01;
        repeat (5) tick();
        check_eq("ioc_output_bit", ioc_flag, 32'h0);

        // Simultaneous port and TRIS writes.
        wr_port = 1'b1; wr_tris = 1'b1; wr_data = 5'h0A;
        tick();
        check_eq("dual_wr_out", pin_out, 32'h0A);
        check_eq("dual_wr_tris", tris_rd_data, 32'h0A);

        // Reset mid-operation discards the pending write; the next edge accepts it.
        wr_tris = 1'b0; wr_data = 5'h1B;
        apply_reset();
        check_eq("rst_discard_wr", pin_out, 32'h00);
        tick();
        check_eq("first_wr_after_rst", pin_out, 32'h1B);
        wr_port = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_port = ($urandom_range(0, 3) == 0);
            wr_tris = ($urandom_range(0, 3) == 0);
            wr_data = W'($urandom);
            rd_port = ($urandom_range(0, 3) == 0);
            ioc_clr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) ioc_mask = W'($urandom);
            if ($urandom_range(0, 3) == 0) pin_in = W'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
